// File: rtl/sorted_vector_serializer_pkg.sv
// Shared definitions for the odd-even merge sorter and its output serializer:
// FSM state encoding, element-index width helper and default geometry.
package sorter_pkg;

  // Default geometry, shared with the merge network.
  localparam int WIDTH_DEF = 3;
  localparam int N_DEF     = 8;

  // Serializer FSM states.
  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  // Width of an index that addresses one of the 2n elements.
  function automatic int idx_width(input int n);
    return $clog2(2 * n);
  endfunction

endpackage

// File: rtl/sorted_vector_serializer_if.sv
// Bundle of the serializer's control, capture and streaming signals.
// Handshake: an element transfers on a rising clk edge where out_valid &&
// out_ready; once out_valid is high it stays high and out_data/out_idx/
// out_last stay unchanged until that transfer happens.
// dbg_state exposes the FSM state for checkers.
interface sorted_vector_serializer_if
  import sorter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int n     = N_DEF
);

  localparam int IW = idx_width(n);

  logic                 start;
  logic [2*n*WIDTH-1:0] in_c;
  logic                 busy;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_data;
  logic [IW-1:0]        out_idx;
  logic                 out_last;
  logic                 done;
  logic                 order_err;
  state_t               dbg_state;

  // Controller / consumer side.
  modport master (
    output start, in_c, out_ready,
    input  busy, out_valid, out_data, out_idx, out_last, done, order_err,
    input  dbg_state
  );

  // Serializer side.
  modport slave (
    input  start, in_c, out_ready,
    output busy, out_valid, out_data, out_idx, out_last, done, order_err,
    output dbg_state
  );

endinterface

// File: rtl/sorted_vector_serializer_elem_select.sv
// 2n:1 element multiplexer: picks element sel out of a packed vector where
// element k occupies bits [(k+1)*WIDTH-1 : k*WIDTH].
module elem_select #(
  parameter int WIDTH = 3,
  parameter int COUNT = 16,
  parameter int SEL_W = 4
) (
  input  logic [COUNT*WIDTH-1:0] vec,
  input  logic [SEL_W-1:0]       sel,
  output logic [WIDTH-1:0]       data
);

  // Plain one-hot style select; COUNT is a power of two so every sel hits.
  always_comb begin
    data = '0;
    for (int k = 0; k < COUNT; k++) begin
      if (sel == SEL_W'(k)) begin
        data = vec[k*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/sorted_vector_serializer.sv
// Serializer behind the 2n-input odd-even merge network: captures the sorted
// vector on start and streams it out one element per cycle over valid/ready.
// Optional SORTED_ORDER_CHECK_EN adds a sticky ascending-order monitor on
// order_err; without it order_err is constant 0.
module sorted_vector_serializer
  import sorter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int n     = N_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  sorted_vector_serializer_if.slave  bus
);

  localparam int            COUNT    = 2 * n;
  localparam int            IW       = idx_width(n);
  localparam logic [IW-1:0] LAST_IDX = IW'(COUNT - 1);

  state_t                 state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic                   done_q, done_d;
  logic                   load;
  logic [COUNT*WIDTH-1:0] shadow_q;
  logic [WIDTH-1:0]       sel_data;
  logic                   streaming;
  logic                   xfer;

  assign streaming = (state_q == STREAM);
  assign xfer      = streaming && bus.out_ready;

  // FSM state, element index and done pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  // Next state: start is only honoured in IDLE, so a start during a stream
  // (including its final handshake) never disturbs the held vector.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          idx_d   = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (bus.out_ready) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Shadow copy of the merged vector, written only on an accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= '0;
    end else if (load) begin
      shadow_q <= bus.in_c;
    end
  end

  elem_select #(
    .WIDTH (WIDTH),
    .COUNT (COUNT),
    .SEL_W (IW)
  ) u_elem_select (
    .vec  (shadow_q),
    .sel  (idx_q),
    .data (sel_data)
  );

  // All outputs derive from registers only; payload reads 0 outside STREAM.
  assign bus.busy      = streaming;
  assign bus.out_valid = streaming;
  assign bus.out_data  = streaming ? sel_data : '0;
  assign bus.out_idx   = idx_q;
  assign bus.out_last  = streaming && (idx_q == LAST_IDX);
  assign bus.done      = done_q;
  assign bus.dbg_state = state_q;

`ifdef SORTED_ORDER_CHECK_EN
  logic [WIDTH-1:0] prev_q;
  logic             err_q;

  // Remember each transferred element and flag any descent; cleared on start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (load) begin
        err_q <= 1'b0;
      end
      if (xfer) begin
        prev_q <= sel_data;
        if ((idx_q != '0) && (sel_data < prev_q)) begin
          err_q <= 1'b1;
        end
      end
    end
  end

  assign bus.order_err = err_q;
`else
  logic unused_xfer;
  assign unused_xfer   = xfer;
  assign bus.order_err = 1'b0;
`endif

endmodule

// File: tb/tb_sorted_vector_serializer.sv
// Directed bench for sorted_vector_serializer (WIDTH=3, n=8).
module tb_sorted_vector_serializer;
  import sorter_pkg::*;

  localparam int W  = 3;
  localparam int N  = 8;
  localparam int VW = 2 * N * W;
`ifdef SORTED_ORDER_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [W-1:0] exp_q[$];

  sorted_vector_serializer_if #(.WIDTH(W), .n(N)) bus ();

  sorted_vector_serializer #(.WIDTH(W), .n(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Hand-written test vectors; element k listed in index order.
  function automatic logic [VW-1:0] mk_vec(input int which);
    logic [VW-1:0] v;
    int d_tab[16] = '{0, 1, 1, 5, 2, 3, 3, 4, 4, 5, 5, 6, 6, 7, 7, 7};
    int c_tab[16] = '{0, 0, 0, 1, 1, 2, 2, 2, 3, 4, 5, 5, 6, 6, 7, 7};
    v = '0;
    for (int k = 0; k < 2 * N; k++) begin
      case (which)
        0:       v[k*W +: W] = W'(k / 2);        // 0,0,1,1,...,7,7
        1:       v[k*W +: W] = W'(k / 4 + 4);    // 4,4,4,4,5,...,7
        2:       v[k*W +: W] = W'(c_tab[k]);
        default: v[k*W +: W] = W'(d_tab[k]);     // descent at index 4
      endcase
    end
    return v;
  endfunction

  task automatic push_vec(input logic [VW-1:0] v);
    for (int k = 0; k < 2 * N; k++) exp_q.push_back(v[k*W +: W]);
  endtask

  // Driver: one-cycle start with in_c, then scramble in_c to prove it is not re-sampled.
  task automatic do_start(input logic [VW-1:0] v);
    bus.start = 1'b1;
    bus.in_c  = v;
    tick();
    bus.start = 1'b0;
    bus.in_c  = ~v;
  endtask

  // Consume one 16-element stream with a repeating ready pattern.
  // inj_at >= 0 pulses start with inj_vec while element inj_at is presented.
  // Returns in the cycle where done is expected high.
  task automatic consume_stream(input logic [3:0] pat, input int inj_at,
                                input logic [VW-1:0] inj_vec, input bit err_vec);
    int nx;
    int cyc;
    nx  = 0;
    cyc = 0;
    while (nx < 2 * N && cyc < 200) begin
      bus.out_ready = pat[2'(cyc % 4)];
      bus.start     = (nx == inj_at);
      if (nx == inj_at) bus.in_c = inj_vec;
      check($sformatf("valid[%0d]", nx), bus.out_valid, 1);
      check($sformatf("busy[%0d]", nx), bus.busy, 1);
      check($sformatf("idx[%0d]", nx), bus.out_idx, nx);
      check($sformatf("data[%0d]", nx), bus.out_data, exp_q[0]);
      check($sformatf("last[%0d]", nx), bus.out_last, (nx == 2 * N - 1));
      check($sformatf("done_low[%0d]", nx), bus.done, 0);
      check($sformatf("order_err[%0d]", nx), bus.order_err, CHK_EN && err_vec && nx >= 5);
      if (bus.out_ready) begin
        void'(exp_q.pop_front());
        nx++;
      end
      tick();
      cyc++;
    end
    bus.start     = 1'b0;
    bus.out_ready = 1'b1;
    if (cyc >= 200) check("stream_timeout", nx, 2 * N);
    check("done_pulse", bus.done, 1);
    check("done_valid_low", bus.out_valid, 0);
    check("done_busy_low", bus.busy, 0);
    check("done_order_err", bus.order_err, CHK_EN && err_vec);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.in_c      = '0;
    bus.out_ready = 1'b1;
    #1;
    check("rst_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_data", bus.out_data, 0);
    check("rst_idx", bus.out_idx, 0);
    check("rst_last", bus.out_last, 0);
    check("rst_done", bus.done, 0);
    check("rst_order_err", bus.order_err, 0);
    check("rst_state", bus.dbg_state, IDLE);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("idle_valid", bus.out_valid, 0);

    // Full-rate stream.
    push_vec(mk_vec(0));
    do_start(mk_vec(0));
    consume_stream(4'b1111, -1, '0, 1'b0);
    tick();
    check("a_done_once", bus.done, 0);
    check("a_idle_valid", bus.out_valid, 0);

    // Ready pattern 1,0,0,1.
    push_vec(mk_vec(0));
    do_start(mk_vec(0));
    consume_stream(4'b1001, -1, '0, 1'b0);
    tick();
    check("stall_done_once", bus.done, 0);

    // Start at idx 5 ignored.
    push_vec(mk_vec(0));
    do_start(mk_vec(0));
    consume_stream(4'b1111, 5, mk_vec(1), 1'b0);
    tick();
    check("inj5_idle", bus.out_valid, 0);

    // Start coincident with the final handshake ignored.
    push_vec(mk_vec(0));
    do_start(mk_vec(0));
    consume_stream(4'b1111, 2 * N - 1, mk_vec(1), 1'b0);
    tick();
    check("inj15_idle", bus.out_valid, 0);
    check("inj15_busy", bus.busy, 0);

    // Asynchronous reset at idx 9.
    do_start(mk_vec(0));
    for (int i = 0; i < 9; i++) tick();
    check("pre_rst_idx", bus.out_idx, 9);
    check("pre_rst_data", bus.out_data, 4);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", bus.out_valid, 0);
    check("arst_busy", bus.busy, 0);
    check("arst_data", bus.out_data, 0);
    check("arst_idx", bus.out_idx, 0);
    check("arst_last", bus.out_last, 0);
    check("arst_done", bus.done, 0);
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_done", bus.done, 0);
    check("post_rst_valid", bus.out_valid, 0);

    // New stream after reset, then back-to-back streams via start in done cycle.
    push_vec(mk_vec(1));
    do_start(mk_vec(1));
    consume_stream(4'b1111, -1, '0, 1'b0);
    push_vec(mk_vec(2));
    do_start(mk_vec(2));
    check("b2b_valid", bus.out_valid, 1);
    check("b2b_idx", bus.out_idx, 0);
    consume_stream(4'b1111, -1, '0, 1'b0);

    // Out-of-order vector, then a start that clears the sticky flag.
    push_vec(mk_vec(3));
    do_start(mk_vec(3));
    consume_stream(4'b1111, -1, '0, 1'b1);
    push_vec(mk_vec(0));
    do_start(mk_vec(0));
    check("err_cleared", bus.order_err, 0);
    consume_stream(4'b1111, -1, '0, 1'b0);
    tick();
    check("final_idle", bus.out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sorted_vector_serializer.md
Name: sorted_vector_serializer

Overview:
- Downstream stage of the 2n-input odd-even merge network.
- Captures the merged, ascending vector of 2n elements in one cycle and streams it out one element per cycle over a valid/ready interface.
- Converts the wide parallel sorter result into a narrow stream for the V2V message/transmit logic.
- A controller pulses start once the merge output is stable, i.e. the cycle after the merger's input register loads.

Parameters:
- WIDTH, 3, bit width of one element (same as the merge network).
- n, 8, half-vector size; the block handles 2n elements (n is a power of two, n >= 2).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  one-cycle pulse: capture in_c and begin streaming.
- in_c  input  2*n*WIDTH  merged vector; element k at bits [(k+1)*WIDTH-1 : k*WIDTH], element 0 is the smallest.
- busy  output  1  high while a vector is held and not fully streamed.
- out_valid  output  1  out_data/out_idx/out_last are valid.
- out_ready  input  1  consumer accepts the current element.
- out_data  output  WIDTH  current element.
- out_idx  output  clog2(2n)  index of the current element.
- out_last  output  1  current element is index 2n-1.
- done  output  1  one-cycle pulse after the final handshake.
- order_err  output  1  sticky ordering violation flag (optional feature; otherwise constant 0).

Behaviour:
- Reset (asynchronous, active-high) clears everything immediately: state=IDLE, shadow register=0, idx=0, and all outputs 0 (busy, out_valid, out_data, out_idx, out_last, done, order_err).
- State IDLE:
  - busy=0, out_valid=0.
  - start=1 -> shadow <= in_c, idx <= 0, state <= STREAM.
  - start=0 -> remain in IDLE.
- State STREAM:
  - busy=1, out_valid=1.
  - out_data = shadow element[idx]; out_idx = idx; out_last = (idx == 2n-1).
- Latency: start sampled at edge k -> out_valid=1 with element 0 after edge k (registered; no combinational path from start or in_c to the outputs).
- Handshake:
  - Transfer occurs when out_valid && out_ready at a rising edge.
  - While out_ready=0, out_data/out_idx/out_last hold stable.
  - On transfer with idx < 2n-1: idx <= idx+1.
  - On transfer with idx == 2n-1: state <= IDLE, idx <= 0, done <= 1 for exactly one cycle (coincident with out_valid=0).
- Throughput: with out_ready held high, 2n elements in 2n consecutive cycles.
- start while in STREAM, including the cycle of the final handshake: ignored; the shadow register is not overwritten.
- start in the cycle done is high: state is IDLE, so it is accepted; the next vector's element 0 is valid on the following cycle.
- in_c is sampled only on an accepted start; changes at any other time have no effect.
- Equal elements are streamed as-is, with no deduplication.
- Reset asserted mid-stream: the stream aborts immediately; no done pulse is generated.

Optional Feature:
- Macro SORTED_ORDER_CHECK_EN.
- Defined:
  - A previous-element register is captured on each transfer.
  - On a transfer with idx > 0 and out_data < previous (unsigned compare), order_err <= 1.
  - order_err is sticky; it is cleared by rst or by an accepted start.
- Undefined:
  - order_err is tied to 0 and no comparison logic is generated.
- The port list is identical in both cases.

Decomposition:
- Shared package sorter_pkg holds:
  - the state encoding (IDLE, STREAM) as a typedef;
  - the index width function clog2(2n);
  - default WIDTH/n constants shared with the merge network.
- One natural sub-module, elem_select: parameterised 2n:1 WIDTH-bit mux, shadow vector plus idx -> out_data.

Test Plan:
- After reset, start with in_c = {7,7,6,6,5,5,4,4,3,3,2,2,1,1,0,0} (element 15 first), out_ready=1:
  - out_data = 0,0,1,1,...,7,7 on 16 consecutive cycles; out_idx = 0..15; out_last only at idx 15;
  - done pulses exactly once, one cycle after the final transfer.
- Same stream with out_ready toggled 1,0,0,1 repeatedly: no element dropped or duplicated; outputs stable while stalled; done after the 16th transfer.
- start pulsed at idx 5 with a different in_c: ignored; remaining elements come from the original vector; busy stays 1.
- rst asserted at idx 9 with out_ready=1: outputs go to 0 without waiting for a clock edge; no done pulse; a new start then streams from idx 0.
- Back-to-back vectors: start in the done cycle -> element 0 of the second vector valid on the next cycle; only one gap cycle between streams.
- With SORTED_ORDER_CHECK_EN: vector with element 3=5 and element 4=2 -> order_err=1 after the transfer of idx 4; stays 1 to end of stream; cleared by the next start. Without the macro: order_err stays 0.
